// File: rtl/axi_ar_rr_arbiter.sv
// Round-robin arbiter sharing one AXI AR initiator port among N requesters.
// Ports: clk, rst (sync, active-high); per-requester arvalid_i/arid_i/ardata_i
// and arready_o; initiator arvalid_o/arid_o/ardata_o/arready_i; rdone_i
// read-completion pulse; outstanding_trans_o / full_counter_o status.
// Optional outstanding limiter: define AXI_AR_ARB_OUTSTANDING_LIMIT_EN.
module axi_ar_rr_arbiter #(
   parameter int N_TARG_PORT     = 4,
   parameter int ID_IN_WIDTH     = 4,
   parameter int ID_OUT_WIDTH    = ID_IN_WIDTH + $clog2(N_TARG_PORT),
   parameter int PAYLOAD_WIDTH   = 64,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [N_TARG_PORT-1:0]                 arvalid_i,
   input  logic [N_TARG_PORT*ID_IN_WIDTH-1:0]     arid_i,
   input  logic [N_TARG_PORT*PAYLOAD_WIDTH-1:0]   ardata_i,
   output logic [N_TARG_PORT-1:0]                 arready_o,
   output logic                                   arvalid_o,
   output logic [ID_OUT_WIDTH-1:0]                arid_o,
   output logic [PAYLOAD_WIDTH-1:0]               ardata_o,
   input  logic                                   arready_i,
   input  logic                                   rdone_i,
   output logic                                   outstanding_trans_o,
   output logic                                   full_counter_o
);

   localparam int IDX_W = $clog2(N_TARG_PORT);

   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t state_q, state_d;
   idx_t   prio_q, prio_d;
   idx_t   lock_q, lock_d;
   idx_t   win, sel;
   logic   found, gnt, vld, hs, full;

   function automatic idx_t wrap_inc(idx_t base, int k);
      int s;
      s = int'(base) + k;
      if (s >= N_TARG_PORT) s = s - N_TARG_PORT;
      return idx_t'(s);
   endfunction

   // first requester at or after the priority pointer
   always_comb begin
      found = 1'b0;
      win   = prio_q;
      for (int k = 0; k < N_TARG_PORT; k++) begin
         if (!found && arvalid_i[wrap_inc(prio_q, k)]) begin
            found = 1'b1;
            win   = wrap_inc(prio_q, k);
         end
      end
   end

   assign sel = (state_q == LOCKED) ? lock_q : win;
   // a locked grant is held even if the limiter is now full
   assign gnt = (state_q == LOCKED) || (found && !full);
   assign vld = gnt && !rst;
   assign hs  = vld && arready_i;

   always_comb begin
      arvalid_o = vld;
      arready_o = '0;
      arid_o    = '0;
      ardata_o  = '0;
      if (vld) begin
         arready_o[sel] = arready_i;
         arid_o   = ID_OUT_WIDTH'({sel, arid_i[sel*ID_IN_WIDTH +: ID_IN_WIDTH]});
         ardata_o = ardata_i[sel*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      lock_d  = lock_q;
      unique case (state_q)
         IDLE: begin
            if (gnt) begin
               if (arready_i) begin
                  prio_d = wrap_inc(win, 1);
               end else begin
                  state_d = LOCKED;
                  lock_d  = win;
               end
            end
         end
         LOCKED: begin
            if (arready_i) begin
               state_d = IDLE;
               prio_d  = wrap_inc(lock_q, 1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= '0;
         lock_q  <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         lock_q  <= lock_d;
      end
   end

`ifdef AXI_AR_ARB_OUTSTANDING_LIMIT_EN
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_W-1:0] cnt_q;

   // simultaneous issue and completion cancel out
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (hs && !rdone_i) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else if (rdone_i && !hs && cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign full                = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign outstanding_trans_o = (cnt_q != '0) && !rst;
   assign full_counter_o      = full && !rst;
`else
   logic unused_ok;

   assign unused_ok           = rdone_i ^ (MAX_OUTSTANDING == 0);
   assign full                = 1'b0;
   assign outstanding_trans_o = 1'b0;
   assign full_counter_o      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Bench for axi_ar_rr_arbiter: directed scenarios plus random traffic
// checked every cycle against a queue-free behavioural arbiter model.
module tb_axi_ar_rr_arbiter;

   localparam int N    = 4;
   localparam int IW   = 4;
   localparam int OW   = 6;
   localparam int PW   = 64;
   localparam int MAXO = 2;

`ifdef AXI_AR_ARB_OUTSTANDING_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    arvalid_i;
   logic [N*IW-1:0] arid_i;
   logic [N*PW-1:0] ardata_i;
   logic [N-1:0]    arready_o;
   logic            arvalid_o;
   logic [OW-1:0]   arid_o;
   logic [PW-1:0]   ardata_o;
   logic            arready_i;
   logic            rdone_i;
   logic            outstanding_trans_o;
   logic            full_counter_o;

   int n_chk  = 0;
   int n_fail = 0;
   logic [N-1:0] hs_vec = '0;

   axi_ar_rr_arbiter #(
      .N_TARG_PORT(N), .ID_IN_WIDTH(IW), .ID_OUT_WIDTH(OW),
      .PAYLOAD_WIDTH(PW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .arvalid_i(arvalid_i), .arid_i(arid_i), .ardata_i(ardata_i),
      .arready_o(arready_o), .arvalid_o(arvalid_o),
      .arid_o(arid_o), .ardata_o(ardata_o),
      .arready_i(arready_i), .rdone_i(rdone_i),
      .outstanding_trans_o(outstanding_trans_o),
      .full_counter_o(full_counter_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model, advanced once per cycle at the falling edge
   int m_ptr = 0, m_lock = 0, m_cnt = 0;
   bit m_locked = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("m_rst_valid", 64'(arvalid_o), 64'd0);
            chk("m_rst_ready", 64'(arready_o), 64'd0);
            chk("m_rst_id", 64'(arid_o), 64'd0);
            chk("m_rst_data", ardata_o, 64'd0);
            chk("m_rst_status", 64'({outstanding_trans_o, full_counter_o}), 64'd0);
            m_ptr = 0; m_lock = 0; m_cnt = 0; m_locked = 1'b0;
            hs_vec = '0;
         end else begin
            bit mfull, ev, hs;
            int g;
            logic [N-1:0]  er;
            logic [OW-1:0] eid;
            logic [PW-1:0] ed;
            mfull = LIMIT && (m_cnt == MAXO);
            ev = 1'b0; g = 0; er = '0; eid = '0; ed = '0;
            if (m_locked) begin
               ev = 1'b1; g = m_lock;
            end else if (!mfull) begin
               for (int k = 0; k < N; k++) begin
                  int idx;
                  idx = (m_ptr + k) % N;
                  if (!ev && arvalid_i[idx]) begin ev = 1'b1; g = idx; end
               end
            end
            if (ev) begin
               er  = arready_i ? N'(1 << g) : '0;
               eid = {2'(g), arid_i[g*IW +: IW]};
               ed  = ardata_i[g*PW +: PW];
            end
            chk("m_arvalid", 64'(arvalid_o), 64'(ev));
            chk("m_arready", 64'(arready_o), 64'(er));
            chk("m_arid", 64'(arid_o), 64'(eid));
            chk("m_ardata", ardata_o, ed);
            chk("m_outst", 64'(outstanding_trans_o), 64'(LIMIT && m_cnt != 0));
            chk("m_full", 64'(full_counter_o), 64'(mfull));
            hs_vec = arready_o & arvalid_i;
            hs = ev && arready_i;
            if (ev) begin
               if (arready_i) begin m_ptr = (g + 1) % N; m_locked = 1'b0; end
               else begin m_locked = 1'b1; m_lock = g; end
            end
            if (hs && !rdone_i) m_cnt++;
            else if (rdone_i && !hs && m_cnt > 0) m_cnt--;
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   int exp_f[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1; arvalid_i = '0; arready_i = 1'b0; rdone_i = 1'b0;
      arid_i = 16'hA531;
      for (int i = 0; i < N; i++)
         ardata_i[i*PW +: PW] = 64'(i + 1) * 64'h0101_0101_0101_0101;

      @(negedge clk);
      chk("rst_valid", 64'(arvalid_o), 64'd0);
      chk("rst_id", 64'(arid_o), 64'd0);
      nxt();
      rst = 1'b0;

      // fairness, rdone with every handshake keeps the count at 0
      arvalid_i = 4'b1111; arready_i = 1'b1; rdone_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("fair_idx", 64'(arid_o[5:4]), 64'(exp_f[i]));
         chk("fair_rdy", 64'(arready_o), 64'(4'b0001 << exp_f[i]));
         nxt();
      end

      // lock on requester 2 while requester 0 also waits (ptr is 1)
      arvalid_i = 4'b0101; arready_i = 1'b0; rdone_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lock_id", 64'(arid_o), 64'h25);
         chk("lock_data", ardata_o, 64'h0303_0303_0303_0303);
         chk("lock_rdy", 64'(arready_o), 64'd0);
         nxt();
      end
      arready_i = 1'b1; rdone_i = 1'b1;
      @(negedge clk);
      chk("lock_hs", 64'(arready_o), 64'b0100);
      nxt();
      arvalid_i = 4'b0001;
      @(negedge clk);
      chk("wrap_idx", 64'(arid_o[5:4]), 64'd0);
      chk("wrap_rdy", 64'(arready_o), 64'b0001);
      nxt();

      // ID tagging
      arvalid_i = 4'b1000;
      @(negedge clk);
      chk("id_tag", 64'(arid_o), 64'b11_1010);
      nxt();

      // reset while locked on requester 2
      arvalid_i = 4'b0010;
      @(negedge clk);
      chk("pre_rdy", 64'(arready_o), 64'b0010);
      nxt();
      arvalid_i = 4'b0100; arready_i = 1'b0; rdone_i = 1'b0;
      @(negedge clk);
      chk("pre_lock", 64'(arid_o[5:4]), 64'd2);
      nxt();
      rst = 1'b1; arvalid_i = 4'b0110;
      @(negedge clk);
      chk("rstl_valid", 64'(arvalid_o), 64'd0);
      chk("rstl_rdy", 64'(arready_o), 64'd0);
      chk("rstl_data", ardata_o, 64'd0);
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("rstl_win", 64'(arid_o[5:4]), 64'd1);
      nxt();
      rst = 1'b1; arvalid_i = '0;
      nxt();
      rst = 1'b0;

`ifdef AXI_AR_ARB_OUTSTANDING_LIMIT_EN
      arvalid_i = 4'b1111; arready_i = 1'b1; rdone_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("lim_issue", 64'(arvalid_o), 64'd1);
         nxt();
      end
      rdone_i = 1'b1;
      @(negedge clk);
      chk("lim_full", 64'(full_counter_o), 64'd1);
      chk("lim_block", 64'(arvalid_o), 64'd0);
      chk("lim_outst", 64'(outstanding_trans_o), 64'd1);
      nxt();
      @(negedge clk);
      chk("lim_unfull", 64'(full_counter_o), 64'd0);
      chk("lim_regrant", 64'(arvalid_o), 64'd1);
      chk("lim_idx", 64'(arid_o[5:4]), 64'd2);
      nxt();
      arvalid_i = '0; arready_i = 1'b0; rdone_i = 1'b0;
      @(negedge clk);
      chk("sim_hold", 64'(outstanding_trans_o), 64'd1);
      nxt();
      rdone_i = 1'b1;
      nxt();
      @(negedge clk);
      chk("sat_zero_a", 64'(outstanding_trans_o), 64'd0);
      nxt();
      rdone_i = 1'b0;
      @(negedge clk);
      chk("sat_zero_b", 64'(outstanding_trans_o), 64'd0);
      chk("sat_full", 64'(full_counter_o), 64'd0);
      nxt();
`else
      arvalid_i = 4'b1111; arready_i = 1'b1; rdone_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("nolim_valid", 64'(arvalid_o), 64'd1);
         chk("nolim_full", 64'(full_counter_o), 64'd0);
         chk("nolim_outst", 64'(outstanding_trans_o), 64'd0);
         nxt();
      end
`endif

      // random traffic; pending requests hold valid/id/data until accepted
      arvalid_i = '0; arready_i = 1'b0; rdone_i = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         nxt();
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            arvalid_i = '0;
         end else begin
            rst = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (!arvalid_i[i] || hs_vec[i]) begin
                  arvalid_i[i] = ($urandom_range(0, 2) != 0);
                  arid_i[i*IW +: IW] = 4'($urandom);
                  ardata_i[i*PW +: PW] = {$urandom, $urandom};
               end
            end
            arready_i = ($urandom_range(0, 3) != 0);
            rdone_i   = ($urandom_range(0, 2) == 0);
         end
      end
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
